passthru_pipe: RTL and testbench
================================

Name: passthru_pipe

Overview:
Parametrised registered successor to the single-bit pass-through wire. It carries a WIDTH-bit word through DEPTH register stages with a valid/ready handshake on both sides. Internal bubbles collapse, backpressure propagates, and a flush clears the pipe. It is the standard in-order delay/retiming element between producer and consumer blocks.

Parameters:
WIDTH, 8, data word width in bits (1..64)
DEPTH, 4, number of register stages (1..16); unobstructed latency in cycles
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer offers in_data this cycle
in_ready  output  1  pipe accepts in_data this cycle
in_data  input  WIDTH  input word
out_valid  output  1  stage DEPTH-1 holds a word
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  WIDTH  word in stage DEPTH-1
flush  input  1  synchronous clear of all stages
count  output  CNT_W  number of occupied stages, 0..DEPTH

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0 and all stage data 0. Therefore out_valid=0, out_data=0, count=0, in_ready=1 once rst_n is high and flush=0. Deassertion is synchronised externally; the block needs no reset synchroniser.
- Stage k holds v[k], d[k]. Stage 0 is the input side and stage DEPTH-1 is the output side.
- Per-stage ready, combinational from the output backwards: r[DEPTH-1] = !v[DEPTH-1] | out_ready; r[k] = !v[k] | r[k+1]. in_ready = r[0] & !flush.
- Transfer into stage k+1 occurs when v[k] & r[k+1]. Stage k+1 then loads d[k] and v[k+1] is set. Stage k clears v[k] unless it is reloaded the same cycle.
- Input transfer: in_valid & in_ready loads stage 0.
- Output transfer: out_valid & out_ready. The word leaves and stage DEPTH-1 may be reloaded in the same cycle, giving full throughput of 1 word/cycle.
- Latency: a word accepted at edge N appears on out_data after edge N+DEPTH-1, first visible in cycle N+DEPTH-1 relative to acceptance, when unobstructed. Its first opportunity to be consumed is DEPTH cycles after acceptance.
- Bubbles collapse: a stalled output never blocks an upstream stage while an empty stage lies between them.
- Order is strictly preserved. No word is dropped or duplicated except by flush.
- Data of an empty stage is don't-care internally. out_data must equal d[DEPTH-1] at all times, including while out_valid=0.
- count: registered, equal to the population count of v[]. It updates on the same edge as the valids and equals (previous count + in_fire - out_fire) when flush=0.
- flush=1: in_ready=0 that cycle, so no input is accepted. On the next edge all v[]=0 and count=0. Any out_fire in the flush cycle still completes, and the consumer sees that word exactly once. Data registers are not cleared.
- Simultaneous flush and reset: reset wins.
- Reset mid-transfer: all words lost, and the outputs return to their reset values immediately, asynchronously.
- Full (count=DEPTH) with out_ready=0: in_ready=0. Full with out_ready=1: in_ready=1, and count is unchanged if in_valid=1.
- Empty: out_valid=0 and count=0. A word enters and then traverses without waiting.
- in_valid is not required to be held by the producer, and the pipe does not check stability.

Decomposition:
- Shared package (pipe_pkg): constant PIPE_MAX_DEPTH=16 and a function clog2_cnt(depth) for CNT_W.
- Sub-module passthru_stage: one WIDTH-bit register plus valid bit, with inputs up_valid, up_data, dn_ready and flush, and outputs valid, data and this stage's ready.
- Top module: a generate loop chains DEPTH instances, plus the count register and elaboration-time parameter range checks.

Test Plan:
- Reset: hold rst_n=0 mid-stream with the pipe part-full. Require out_valid=0, out_data=0, count=0 immediately. After release with flush=0, require in_ready=1.
- Streaming, DEPTH=4, WIDTH=8: send 0x01..0x10 on consecutive cycles with out_ready=1. Require the first out_valid 4 cycles after the first accept, the same order, one word/cycle, and count steady at 4.
- Backpressure: out_ready=0 and send 6 words. Require count to reach 4, in_ready=0 after the 4th accept, and words 5-6 held by the producer. Then raise out_ready=1 and require 0x01..0x06 in order with no gaps.
- Bubble collapse: send one word, stall out_ready for 3 cycles, send 3 more while stalled. Require all 4 stages occupied (count=4) before the output is released.
- Flush: fill 3 words and assert flush for 1 cycle with out_ready=1 and in_valid=1. Require the head word consumed once, the input not accepted that cycle, and count=0 and out_valid=0 the next cycle.
- Parameter sweep: DEPTH=1, WIDTH=1 and DEPTH=16, WIDTH=64 with random valid/ready. Require a scoreboard match and count=in_fires-out_fires throughout.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the registered pass-through pipe.
package pipe_pkg;

    localparam int unsigned PIPE_MAX_DEPTH = 16;
    localparam int unsigned PIPE_MAX_WIDTH = 64;

    // Width needed to hold an occupancy count in 0..depth.
    function automatic int unsigned clog2_cnt(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/passthru_stage.sv
// One pipe stage: a data register plus valid bit with a skid-free ready chain.
module passthru_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    input  logic             flush,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_load;

    // Empty stages always accept, so bubbles collapse toward the output.
    assign ready  = ~r_valid | dn_ready;
    assign w_load = up_valid & ready;
    assign valid  = r_valid;
    assign data   = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
            end else if (dn_ready) begin
                r_valid <= 1'b0;
            end
            if (w_load) begin
                r_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/passthru_pipe.sv
// In-order WIDTH x DEPTH register pipe with valid/ready on both sides, bubble
// collapse, synchronous flush and a registered occupancy count.
module passthru_pipe
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = clog2_cnt(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    if (WIDTH < 1 || WIDTH > PIPE_MAX_WIDTH) begin : g_bad_width
        $error("passthru_pipe: WIDTH out of range");
    end
    if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
        $error("passthru_pipe: DEPTH out of range");
    end
    if (CNT_W != clog2_cnt(DEPTH)) begin : g_bad_cnt_w
        $error("passthru_pipe: CNT_W must not be overridden");
    end

    logic             w_in_fire;
    logic             w_out_fire;
    logic [CNT_W-1:0] r_count;

    // Per-stage nets live inside each generate block so the ready chain is
    // not one self-referencing vector.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             w_up_valid;
        logic             w_dn_ready;
        logic             w_valid;
        logic             w_ready;
        logic [WIDTH-1:0] w_up_data;
        logic [WIDTH-1:0] w_data;

        if (k == 0) begin : g_first
            assign w_up_valid = in_valid & ~flush;
            assign w_up_data  = in_data;
        end else begin : g_chain
            assign w_up_valid = g_stage[k-1].w_valid;
            assign w_up_data  = g_stage[k-1].w_data;
        end

        if (k == DEPTH - 1) begin : g_last
            assign w_dn_ready = out_ready;
        end else begin : g_mid
            assign w_dn_ready = g_stage[k+1].w_ready;
        end

        passthru_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .up_valid(w_up_valid),
            .up_data (w_up_data),
            .dn_ready(w_dn_ready),
            .flush   (flush),
            .valid   (w_valid),
            .data    (w_data),
            .ready   (w_ready)
        );
    end

    assign in_ready   = g_stage[0].w_ready & ~flush;
    assign out_valid  = g_stage[DEPTH-1].w_valid;
    assign out_data   = g_stage[DEPTH-1].w_data;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign count      = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_in_fire, w_out_fire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_passthru_pipe.sv
// Scoreboard bench: directed tests on a DEPTH=4/WIDTH=8 pipe plus random
// valid/ready sweeps on DEPTH=1/WIDTH=1 and DEPTH=16/WIDTH=64 instances.
module tb_passthru_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Main instance
    logic       in_valid, in_ready, out_valid, out_ready, flush;
    logic [7:0] in_data, out_data;
    logic [2:0] count;

    // Sweep instances
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [0:0]  s_in_data, s_out_data, s_count;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_in_data, b_out_data;
    logic [4:0]  b_count;
    logic        no_flush = 1'b0;

    passthru_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .count(count)
    );

    passthru_pipe #(.WIDTH(1), .DEPTH(1)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .flush(no_flush), .count(s_count)
    );

    passthru_pipe #(.WIDTH(64), .DEPTH(16)) u_big (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .flush(no_flush), .count(b_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Main scoreboard: stimulus pushes, monitor pops.
    logic [7:0] exp_q[$];
    int         m_cnt = 0;
    int         n_out = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_cnt = 0;
        end else begin
            chk("main_count", 64'(count), 64'(m_cnt));
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("main_unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    chk("main_out_data", 64'(out_data), 64'(exp_q.pop_front()));
                end
            end
            if (flush) m_cnt = 0;
            else m_cnt = m_cnt + int'(in_valid && in_ready) - int'(out_valid && out_ready);
        end
    end

    // Sweep scoreboards: pushed on input handshake, popped on output handshake.
    logic [63:0] s_q[$];
    logic [63:0] b_q[$];
    int          s_cnt = 0;
    int          b_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            s_cnt = 0;
            b_cnt = 0;
        end else begin
            chk("small_count", 64'(s_count), 64'(s_cnt));
            chk("big_count", 64'(b_count), 64'(b_cnt));
            if (s_out_valid && s_out_ready) begin
                if (s_q.size() == 0) chk("small_unexpected_out", 64'(s_out_valid), 64'd0);
                else chk("small_out_data", 64'(s_out_data), s_q.pop_front());
                s_cnt--;
            end
            if (s_in_valid && s_in_ready) begin
                s_q.push_back(64'(s_in_data));
                s_cnt++;
            end
            if (b_out_valid && b_out_ready) begin
                if (b_q.size() == 0) chk("big_unexpected_out", 64'(b_out_valid), 64'd0);
                else chk("big_out_data", b_out_data, b_q.pop_front());
                b_cnt--;
            end
            if (b_in_valid && b_in_ready) begin
                b_q.push_back(b_in_data);
                b_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; must be called just after a rising edge.
    task automatic send(input logic [7:0] w);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(w);
                ok = 1'b1;
                break;
            end
        end
        chk("send_accepted", 64'(ok), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (int'(count) == n) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_count", 64'(ok), 64'd1);
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && count == 3'd0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        {in_valid, out_ready, flush} = '0;
        in_data = '0;
        {s_in_valid, s_out_ready, b_in_valid, b_out_ready} = '0;
        s_in_data = '0;
        b_in_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Streaming at full throughput
        out_ready = 1'b1;
        fork
            begin
                for (int i = 1; i <= 16; i++) send(8'(i));
            end
            begin
                int n = 0;
                bit seen = 1'b0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    if (in_valid && in_ready) seen = 1'b1;
                end
                for (n = 1; n <= 10; n++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                chk("stream_latency", 64'(n), 64'd4);
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    chk("stream_out_valid", 64'(out_valid), 64'd1);
                    chk("stream_count_full", 64'(count), 64'd4);
                end
            end
        join
        drain("stream_drained");

        // Backpressure
        step();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) send(8'(i));
            end
            begin
                wait_cnt(4);
                chk("bp_in_ready_full", 64'(in_ready), 64'd0);
                repeat (3) @(negedge clk);
                chk("bp_count_held", 64'(count), 64'd4);
                chk("bp_accepted", 64'(exp_q.size()), 64'd4);
                step();
                base = n_out;
                out_ready = 1'b1;
                repeat (6) @(negedge clk);
                #1;
                chk("bp_no_gaps", 64'(n_out - base), 64'd6);
            end
        join
        drain("bp_drained");

        // Bubble collapse
        step();
        out_ready = 1'b0;
        send(8'hA1);
        repeat (3) @(posedge clk);
        #1;
        send(8'hA2);
        send(8'hA3);
        send(8'hA4);
        wait_cnt(4);
        chk("bubble_out_valid", 64'(out_valid), 64'd1);
        chk("bubble_head", 64'(out_data), 64'hA1);
        step();
        out_ready = 1'b1;
        drain("bubble_drained");

        // Flush with a concurrent output handshake and offered input
        step();
        out_ready = 1'b0;
        send(8'hB1);
        send(8'hB2);
        send(8'hB3);
        wait_cnt(3);
        step();
        base = n_out;
        flush = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hEE;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_head_once", 64'(n_out - base), 64'd1);
        exp_q.delete();
        repeat (5) @(negedge clk);
        #1;
        chk("flush_no_extra", 64'(n_out - base), 64'd1);

        // Asynchronous reset mid-stream
        step();
        out_ready = 1'b0;
        send(8'hC1);
        send(8'hC2);
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_out_data", 64'(out_data), 64'hC1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_data", 64'(out_data), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Random valid/ready sweep on the extreme configurations
        for (int c = 0; c < 600; c++) begin
            step();
            s_in_valid  = 1'($urandom_range(0, 1));
            s_out_ready = 1'($urandom_range(0, 1));
            s_in_data   = 1'($urandom);
            b_in_valid  = 1'($urandom_range(0, 1));
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_in_data   = {$urandom, $urandom};
        end
        step();
        s_in_valid  = 1'b0;
        b_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        b_out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("small_drained", 64'(s_q.size()), 64'd0);
        chk("big_drained", 64'(b_q.size()), 64'd0);
        chk("small_final_count", 64'(s_count), 64'd0);
        chk("big_final_count", 64'(b_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
